hs_arbiter: RTL and testbench

- Shares one downstream four-phase req/ack channel (the reader) between NREQ upstream writers.
- Round-robin selection; latches the winner's data and runs the full four-phase cycle downstream while holding all other writers off.
- Sits between the writer instances and a single reader; both sides use the same req/ack/data protocol as the existing writer/reader pair.

---
 rtl/hs_arbiter.sv | 111 +++++++++++
 tb/tb_hs_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_arbiter.sv
// Round-robin arbiter sharing one four-phase req/ack reader among NREQ writers.
// The winner's data is latched and the full handshake runs downstream before the next grant.
module hs_arbiter #(
    parameter int NREQ = 2,
    parameter int W = 8,
    parameter int CW = 16,
    localparam int GW = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_i,
    input  logic [NREQ*W-1:0] data_i,
    output logic [NREQ-1:0]   ack_o,
    output logic              req_o,
    input  logic              ack_i,
    output logic [W-1:0]      q,
    output logic [GW-1:0]     grant,
    output logic              busy,
    output logic [CW-1:0]     xfer_count
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, REL} state_t;

    state_t          state, state_n;
    logic [GW-1:0]   last_grant, last_n;
    logic [GW-1:0]   grant_n, winner, idx;
    logic [W-1:0]    q_n;
    logic [NREQ-1:0] ack_n;
    logic [CW-1:0]   cnt_n;
    logic            req_n, busy_n, found;

    // First requester strictly after the last served writer, with wrap.
    always_comb begin
        winner = '0;
        found = 1'b0;
        idx = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = GW'((int'(last_grant) + i) % NREQ);
            if (!found && req_i[idx]) begin
                found = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        state_n = state;
        req_n = req_o;
        ack_n = ack_o;
        q_n = q;
        grant_n = grant;
        last_n = last_grant;
        cnt_n = xfer_count;
        unique case (state)
            IDLE: begin
                if (found) begin
                    grant_n = winner;
                    q_n = data_i[int'(winner)*W +: W];
                    req_n = 1'b1;
                    state_n = REQ;
                end
            end
            REQ: begin
                if (ack_i) begin
                    ack_n = '0;
                    ack_n[grant] = 1'b1;
                    state_n = HOLD;
                end
            end
            HOLD: begin
                if (!req_i[grant]) begin
                    req_n = 1'b0;
                    state_n = REL;
                end
            end
            REL: begin
                if (!ack_i) begin
                    ack_n = '0;
                    last_n = grant;
                    cnt_n = xfer_count + CW'(1);
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            req_o <= 1'b0;
            ack_o <= '0;
            q <= '0;
            grant <= '0;
            busy <= 1'b0;
            xfer_count <= '0;
            last_grant <= GW'(NREQ - 1);
        end else begin
            state <= state_n;
            req_o <= req_n;
            ack_o <= ack_n;
            q <= q_n;
            grant <= grant_n;
            busy <= busy_n;
            xfer_count <= cnt_n;
            last_grant <= last_n;
        end
    end

endmodule

// File: tb/tb_hs_arbiter.sv
// Bench for hs_arbiter: directed vectors, handshake corner cases and
// randomized writer/reader agents checked against a transaction-level model.
module tb_hs_arbiter;

    localparam int NREQ = 2;
    localparam int W = 8;
    localparam int CW = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NREQ-1:0]   req_i = '0;
    logic [NREQ*W-1:0] data_i = '0;
    logic [NREQ-1:0]   ack_o;
    logic              req_o;
    logic              ack_i = 1'b0;
    logic [W-1:0]      q;
    logic [0:0]        grant;
    logic              busy;
    logic [CW-1:0]     xfer_count;

    hs_arbiter #(.NREQ(NREQ), .W(W), .CW(CW)) dut (
        .clk(clk),
        .reset(reset),
        .req_i(req_i),
        .data_i(data_i),
        .ack_o(ack_o),
        .req_o(req_o),
        .ack_i(ack_i),
        .q(q),
        .grant(grant),
        .busy(busy),
        .xfer_count(xfer_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // agents: writer mode 0 off, 1 one-shot, 2 continuous, 3 random gaps
    int wmode[NREQ];
    int wst[NREQ];
    int wcnt[NREQ];
    int waited[NREQ];
    bit wused[NREQ];
    logic [W-1:0] wdat[NREQ];
    int rdly, rcnt;
    bit rrand, auto_en, mon_en;

    // transaction-level reference state
    int m_last, m_count, n_xfer, ncyc, last_fall;
    logic o_req;
    logic [NREQ-1:0] o_ack;
    logic [0:0] o_grant;
    logic [W-1:0] o_q;
    logic [NREQ-1:0] req_at;
    logic [NREQ*W-1:0] dat_at;
    logic acki_at, acki_pp;
    int served[$];
    logic [W-1:0] served_q[$];
    int cnts[$];

    typedef struct {
        logic [1:0]  req;
        logic [15:0] data;
        logic        ack;
        logic        rq;
        logic [1:0]  ak;
        logic        bz;
        logic        g;
        logic [7:0]  qq;
        logic [3:0]  cnt;
    } vec_t;

    vec_t vt[20];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int last);
        for (int i = 1; i <= NREQ; i++) begin
            int j;
            j = (last + i) % NREQ;
            if (((r >> j) & NREQ'(1)) != 0) return j;
        end
        return -1;
    endfunction

    task automatic drive_data();
        for (int k = 0; k < NREQ; k++) data_i[k*W +: W] = wdat[k];
    endtask

    task automatic monitor();
        logic [NREQ-1:0] gmask;
        int e;
        gmask = '0;
        gmask[grant] = 1'b1;
        chk("ack_onehot", 64'($countones(ack_o) <= 1), 1);
        chk("ack_granted_only", 64'(ack_o & ~gmask), 0);
        chk("busy", 64'(busy), 64'(req_o || (ack_o != 0)));
        if (req_o && !o_req) begin
            e = rr_pick(req_at, m_last);
            chk("rr_grant", 64'(grant), 64'(e));
            if (e < 0) e = 0;
            chk("grant_data", 64'(q), 64'(dat_at[e*W +: W]));
            chk("idle_gap", 64'(ncyc - last_fall >= 1), 1);
            served.push_back(int'(grant));
            served_q.push_back(q);
        end else begin
            chk("hold_grant_q", {grant, q}, {o_grant, o_q});
        end
        if (ack_o != 0 && o_ack == 0) begin
            chk("ack_rise_lat", {acki_pp, acki_at}, 2'b01);
            chk("fair", 64'(waited[grant] <= NREQ - 1), 1);
            waited[grant] = 0;
        end
        if (!req_o && o_req) chk("req_fall_lat", 64'(req_at[grant]), 0);
        if (ack_o == 0 && o_ack != 0) begin
            chk("ack_fall_lat", {acki_pp, acki_at}, 2'b10);
            m_count++;
            n_xfer++;
            m_last = int'(grant);
            last_fall = ncyc;
            cnts.push_back(int'(xfer_count));
            for (int k = 0; k < NREQ; k++)
                if (k != int'(grant) && wst[k] == 1) waited[k]++;
        end
        chk("count", 64'(xfer_count), 64'(m_count % (1 << CW)));
        o_req = req_o;
        o_ack = ack_o;
        o_grant = grant;
        o_q = q;
    endtask

    task automatic agents();
        for (int k = 0; k < NREQ; k++) begin
            case (wst[k])
                0: if (wmode[k] != 0 && !(wmode[k] == 1 && wused[k])) begin
                    if (wcnt[k] == 0) begin
                        if (wmode[k] != 1) wdat[k] = W'($urandom);
                        req_i[k] = 1'b1;
                        wst[k] = 1;
                    end else wcnt[k]--;
                end
                1: if (ack_o[k]) begin
                    req_i[k] = 1'b0;
                    wst[k] = 2;
                end
                default: if (!ack_o[k]) begin
                    wst[k] = 0;
                    wused[k] = 1'b1;
                    wcnt[k] = (wmode[k] == 3) ? int'($urandom_range(0, 4)) : 0;
                end
            endcase
        end
        drive_data();
        if (ack_i != req_o) begin
            if (rcnt == 0) begin
                ack_i = req_o;
                rcnt = rrand ? int'($urandom_range(0, 3)) : rdly;
            end else rcnt--;
        end
    endtask

    task automatic cycle();
        logic [NREQ-1:0] r_n;
        logic [NREQ*W-1:0] d_n;
        logic a_n;
        r_n = req_i;
        d_n = data_i;
        a_n = ack_i;
        @(posedge clk);
        #1;
        ncyc++;
        acki_pp = acki_at;
        acki_at = a_n;
        req_at = r_n;
        dat_at = d_n;
        if (mon_en) monitor();
        if (auto_en) agents();
    endtask

    task automatic do_reset();
        auto_en = 1'b0;
        mon_en = 1'b0;
        reset = 1'b0;
        req_i = '0;
        ack_i = 1'b0;
        data_i = '0;
        #1;
        chk("reset_outputs", {req_o, ack_o, busy, q, grant, xfer_count}, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        for (int k = 0; k < NREQ; k++) begin
            wmode[k] = 0;
            wst[k] = 0;
            wcnt[k] = 0;
            waited[k] = 0;
            wused[k] = 1'b0;
            wdat[k] = '0;
        end
        rdly = 0;
        rcnt = 0;
        rrand = 1'b0;
        m_last = NREQ - 1;
        m_count = 0;
        n_xfer = 0;
        ncyc = 0;
        last_fall = -10;
        o_req = 1'b0;
        o_ack = '0;
        o_grant = '0;
        o_q = '0;
        req_at = '0;
        dat_at = '0;
        acki_at = 1'b0;
        acki_pp = 1'b0;
        served.delete();
        served_q.delete();
        cnts.delete();
    endtask

    task automatic go();
        rcnt = rdly;
        auto_en = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic run_xfers(input int n, input int maxc, input string nm);
        int c;
        c = 0;
        while (n_xfer < n && c < maxc) begin
            cycle();
            c++;
        end
        if (n_xfer < n) chk({nm, "_timeout"}, 64'(n_xfer), 64'(n));
    endtask

    initial begin
        vt[0]  = '{2'b00, 16'h0000, 0, 0, 2'b00, 0, 0, 8'h00, 4'd0};
        vt[1]  = '{2'b10, 16'h5A00, 0, 1, 2'b00, 1, 1, 8'h5A, 4'd0};
        vt[2]  = '{2'b10, 16'h5A00, 0, 1, 2'b00, 1, 1, 8'h5A, 4'd0};
        vt[3]  = '{2'b10, 16'h5A00, 0, 1, 2'b00, 1, 1, 8'h5A, 4'd0};
        vt[4]  = '{2'b10, 16'h5A00, 1, 1, 2'b10, 1, 1, 8'h5A, 4'd0};
        vt[5]  = '{2'b00, 16'h5A00, 1, 0, 2'b10, 1, 1, 8'h5A, 4'd0};
        vt[6]  = '{2'b00, 16'h5A00, 1, 0, 2'b10, 1, 1, 8'h5A, 4'd0};
        vt[7]  = '{2'b00, 16'h5A00, 0, 0, 2'b00, 0, 1, 8'h5A, 4'd1};
        vt[8]  = '{2'b01, 16'h0011, 0, 1, 2'b00, 1, 0, 8'h11, 4'd1};
        vt[9]  = '{2'b01, 16'h0011, 1, 1, 2'b01, 1, 0, 8'h11, 4'd1};
        vt[10] = '{2'b00, 16'h0011, 1, 0, 2'b01, 1, 0, 8'h11, 4'd1};
        vt[11] = '{2'b00, 16'h0011, 0, 0, 2'b00, 0, 0, 8'h11, 4'd2};
        vt[12] = '{2'b11, 16'h2233, 0, 1, 2'b00, 1, 1, 8'h22, 4'd2};
        vt[13] = '{2'b11, 16'h2233, 1, 1, 2'b10, 1, 1, 8'h22, 4'd2};
        vt[14] = '{2'b01, 16'h2233, 1, 0, 2'b10, 1, 1, 8'h22, 4'd2};
        vt[15] = '{2'b01, 16'h2233, 0, 0, 2'b00, 0, 1, 8'h22, 4'd3};
        vt[16] = '{2'b01, 16'h2233, 0, 1, 2'b00, 1, 0, 8'h33, 4'd3};
        vt[17] = '{2'b01, 16'h2233, 1, 1, 2'b01, 1, 0, 8'h33, 4'd3};
        vt[18] = '{2'b00, 16'h2233, 1, 0, 2'b01, 1, 0, 8'h33, 4'd3};
        vt[19] = '{2'b00, 16'h2233, 0, 0, 2'b00, 0, 0, 8'h33, 4'd4};

        #2;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            req_i = vt[i].req;
            data_i = vt[i].data;
            ack_i = vt[i].ack;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", i),
                {req_o, ack_o, busy, grant, q, xfer_count},
                {vt[i].rq, vt[i].ak, vt[i].bz, vt[i].g, vt[i].qq, vt[i].cnt});
        end

        // simultaneous one-shot requests right after reset
        do_reset();
        wmode[0] = 1;
        wmode[1] = 1;
        wdat[0] = 8'h11;
        wdat[1] = 8'h22;
        go();
        run_xfers(2, 100, "simul");
        chk("simul_n", 64'(served.size()), 2);
        if (served.size() >= 2) begin
            chk("simul_first", {8'(served[0]), served_q[0]}, {8'd0, 8'h11});
            chk("simul_second", {8'(served[1]), served_q[1]}, {8'd1, 8'h22});
        end

        // continuous contention alternates grants
        do_reset();
        wmode[0] = 2;
        wmode[1] = 2;
        go();
        run_xfers(6, 200, "cont");
        for (int i = 0; i < 6 && i < served.size(); i++)
            chk($sformatf("cont_grant%0d", i), 64'(served[i]), 64'(i % 2));

        // slow reader: ten-cycle delay on each phase
        do_reset();
        wmode[0] = 1;
        wdat[0] = 8'hC3;
        rdly = 10;
        go();
        run_xfers(1, 200, "slow");
        chk("slow_len", 64'(last_fall >= 22), 1);
        if (served_q.size() >= 1) chk("slow_q", 64'(served_q[0]), 8'hC3);

        // asynchronous reset while holding
        do_reset();
        wmode[0] = 1;
        wdat[0] = 8'h77;
        go();
        for (int c = 0; c < 20 && ack_o == 0; c++) cycle();
        chk("reach_hold", 64'(ack_o != 0 && req_o), 1);
        reset = 1'b0;
        #1;
        chk("reset_hold", {req_o, ack_o, busy, xfer_count}, 0);
        do_reset();
        wmode[0] = 2;
        wmode[1] = 2;
        go();
        run_xfers(1, 100, "post_reset");
        if (served.size() >= 1) chk("post_reset_grant", 64'(served[0]), 0);

        // counter wrap with a 4-bit counter
        do_reset();
        wmode[0] = 2;
        go();
        run_xfers(17, 400, "wrap");
        if (cnts.size() >= 17) begin
            chk("wrap15", 64'(cnts[14]), 15);
            chk("wrap16", 64'(cnts[15]), 0);
            chk("wrap17", 64'(cnts[16]), 1);
        end

        // randomized writers and reader
        do_reset();
        wmode[0] = 3;
        wmode[1] = 3;
        rrand = 1'b1;
        go();
        repeat (3000) cycle();
        chk("rand_progress", 64'(n_xfer > 50), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
